demux_1n_stream: RTL and testbench

- Parametrised, registered successor to the combinational 1-to-8 demultiplexer.
- Routes one input stream to one of CHANNELS output streams, or broadcasts it to all of them.
- Each output channel has a one-entry output register with a valid/ready handshake.
- Sits between a single producer and CHANNELS independent consumers; out-of-range selects are dropped and counted.

---
 rtl/demux_pkg.sv | 15 +
 rtl/demux_chan_reg.sv | 32 +++
 rtl/demux_1n_stream.sv | 84 ++++++++
 tb/tb_demux_1n_stream.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared defaults and helpers for the 1-to-N registered stream demux.
// No logic state lives here.
// Imported by the channel register and the demux top.
package demux_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 8;
    localparam int DEF_CNT_W    = 8;

    // Non-power-of-two channel counts leave select codes with no channel behind them.
    function automatic logic sel_in_range(input int sel, input int channels);
        return sel < channels;
    endfunction

endpackage

// File: rtl/demux_chan_reg.sv
// One-entry output register with a valid/ready handshake.
// Latency: 1 cycle from load to out_valid.
// Backpressure: holds the word while out_ready=0; can drain and refill in one cycle.
module demux_chan_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             can_accept
);

    assign can_accept = ~out_valid | out_ready;

    // Load beats drain, so a full register handed a new word stays valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_1n_stream.sv
// Routes one input stream to one of CHANNELS outputs, or broadcasts to all.
// Latency: 1 cycle; out-of-range selects are swallowed and counted.
// Backpressure: in_ready follows the target channel(s); a broadcast waits for every channel.
module demux_1n_stream
    import demux_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_W-1:0]          in_sel,
    input  logic                      in_bcast,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]          drop_cnt,
    output logic                      drop_pulse
);

    logic [CHANNELS-1:0] can_accept;
    logic [CHANNELS-1:0] load;
    logic                sel_ok;
    logic                xfer;
    logic                drop;

    assign sel_ok = sel_in_range(int'(in_sel), CHANNELS);
    assign xfer   = in_valid & in_ready;
    assign drop   = xfer & ~in_bcast & ~sel_ok;

    // A dropped word has nowhere to wait, so it is always accepted.
    always_comb begin
        in_ready = 1'b1;
        if (in_bcast) begin
            in_ready = &can_accept;
        end else if (sel_ok) begin
            in_ready = can_accept[in_sel];
        end
    end

    always_comb begin
        load = '0;
        if (xfer) begin
            if (in_bcast) begin
                load = '1;
            end else if (sel_ok) begin
                load[in_sel] = 1'b1;
            end
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        demux_chan_reg #(
            .WIDTH (WIDTH)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (load[k]),
            .d          (in_data),
            .out_valid  (out_valid[k]),
            .out_ready  (out_ready[k]),
            .out_data   (out_data[k*WIDTH +: WIDTH]),
            .can_accept (can_accept[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt   <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop;
            if (drop && (drop_cnt != {CNT_W{1'b1}})) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux_1n_stream.sv
// Bench for demux_1n_stream: an 8-channel instance and a 5-channel, 2-bit-counter instance.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_demux_1n_stream;

    logic clk;
    logic rst_n;

    logic        in_valid, in_ready, in_bcast, drop_pulse;
    logic [7:0]  in_data, out_valid, out_ready, drop_cnt;
    logic [2:0]  in_sel;
    logic [63:0] out_data;

    logic        p_in_valid, p_in_ready, p_in_bcast, p_drop_pulse;
    logic [7:0]  p_in_data;
    logic [2:0]  p_in_sel;
    logic [4:0]  p_out_valid, p_out_ready;
    logic [39:0] p_out_data;
    logic [1:0]  p_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    demux_1n_stream u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_sel(in_sel), .in_bcast(in_bcast),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .drop_cnt(drop_cnt), .drop_pulse(drop_pulse)
    );

    demux_1n_stream #(.WIDTH(8), .CHANNELS(5), .CNT_W(2)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in_data(p_in_data), .in_sel(p_in_sel), .in_bcast(p_in_bcast),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
        .drop_cnt(p_drop_cnt), .drop_pulse(p_drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] ch8(input logic [63:0] v, input int k);
        return v[k*8 +: 8];
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 0; in_bcast = 0; in_sel = 0; in_data = 0; out_ready = 8'hFF;
        p_in_valid = 0; p_in_bcast = 0; p_in_sel = 0; p_in_data = 0; p_out_ready = 5'h1F;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1; in_sel = 3; in_data = 8'hA5; out_ready = 8'h00;
        p_in_valid = 1; p_in_sel = 7; p_in_data = 8'h01;
        @(negedge clk);
        in_valid = 0; p_in_valid = 0;
        n_checks++;
        if (out_valid !== 8'h08 || ch8(out_data, 3) !== 8'hA5) begin
            n_fail++;
            $display("FAIL reset_prefill: valid=%h data3=%h, required 08/a5", out_valid, ch8(out_data, 3));
        end
        n_checks++;
        if (p_drop_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_prefill_drop: cnt=%0d, required 1", p_drop_cnt);
        end
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 8'h00 || out_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_async_out: valid=%h data=%h, required 0/0", out_valid, out_data);
        end
        n_checks++;
        if (drop_cnt !== 8'd0 || drop_pulse !== 1'b0 || p_drop_cnt !== 2'd0 || p_out_valid !== 5'h0) begin
            n_fail++;
            $display("FAIL reset_async_cnt: cnt=%0d pulse=%b p_cnt=%0d p_valid=%h, required all 0",
                     drop_cnt, drop_pulse, p_drop_cnt, p_out_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 8'hFF;
        @(negedge clk);
    endtask

    task automatic test_unicast_sweep();
        out_ready = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_checks++;
                if (out_valid !== 8'(1 << (k - 1)) || ch8(out_data, k - 1) !== 8'(8'h10 + k - 1)) begin
                    n_fail++;
                    $display("FAIL sweep_out k=%0d: valid=%h data=%h, required %h/%h", k - 1, out_valid,
                             ch8(out_data, k - 1), 8'(1 << (k - 1)), 8'(8'h10 + k - 1));
                end
            end
            in_valid = (k < 8);
            in_sel   = 3'(k);
            in_data  = 8'(8'h10 + k);
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL sweep_ready k=%0d: in_ready=%b, required 1", k, in_ready);
            end
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 8'h00) begin
            n_fail++;
            $display("FAIL sweep_drain: valid=%h, required 00", out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 8'hFB;
        @(negedge clk);
        in_valid = 1; in_bcast = 0; in_sel = 2; in_data = 8'h11;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: %b, required 1", in_ready); end
        @(negedge clk);
        in_data = 8'h22;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid[2] !== 1'b1 || ch8(out_data, 2) !== 8'h11) begin
            n_fail++;
            $display("FAIL bp_stall: ready=%b v2=%b d2=%h, required 0/1/11", in_ready, out_valid[2], ch8(out_data, 2));
        end
        @(negedge clk);
        n_checks++;
        if (out_valid[2] !== 1'b1 || ch8(out_data, 2) !== 8'h11) begin
            n_fail++;
            $display("FAIL bp_hold: v2=%b d2=%h, required 1/11", out_valid[2], ch8(out_data, 2));
        end
        in_sel = 5; in_data = 8'h55;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_other_ready: %b, required 1", in_ready); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 8'h24 || ch8(out_data, 5) !== 8'h55 || ch8(out_data, 2) !== 8'h11) begin
            n_fail++;
            $display("FAIL bp_other_flow: valid=%h d5=%h d2=%h, required 24/55/11", out_valid,
                     ch8(out_data, 5), ch8(out_data, 2));
        end
        in_sel = 2; in_data = 8'h22;
        out_ready = 8'hFF;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: %b, required 1", in_ready); end
        @(negedge clk);
        in_valid = 0;
        n_checks++;
        if (out_valid !== 8'h04 || ch8(out_data, 2) !== 8'h22) begin
            n_fail++;
            $display("FAIL bp_refill: valid=%h d2=%h, required 04/22", out_valid, ch8(out_data, 2));
        end
        @(negedge clk);
    endtask

    task automatic test_broadcast();
        out_ready = 8'hBF;
        in_valid = 1; in_bcast = 0; in_sel = 6; in_data = 8'h66;
        @(negedge clk);
        in_bcast = 1; in_data = 8'h3C;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 8'h40) begin
            n_fail++;
            $display("FAIL bcast_block: ready=%b valid=%h, required 0/40", in_ready, out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 8'h40 || ch8(out_data, 6) !== 8'h66) begin
            n_fail++;
            $display("FAIL bcast_no_partial: valid=%h d6=%h, required 40/66", out_valid, ch8(out_data, 6));
        end
        out_ready = 8'hFF;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bcast_release_ready: %b, required 1", in_ready); end
        @(negedge clk);
        in_valid = 0; in_bcast = 0;
        for (int k = 0; k < 8; k++) begin
            n_checks++;
            if (out_valid[k] !== 1'b1 || ch8(out_data, k) !== 8'h3C) begin
                n_fail++;
                $display("FAIL bcast_all ch%0d: v=%b d=%h, required 1/3c", k, out_valid[k], ch8(out_data, k));
            end
        end
        @(negedge clk);
    endtask

    // Five drops in a row on the 5-channel instance, counter saturating at 3.
    task automatic test_out_of_range_saturation();
        p_out_ready = 5'h1F;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if (p_drop_pulse !== 1'b1 || p_drop_cnt !== 2'((i > 3) ? 3 : i) || p_out_valid !== 5'h0) begin
                    n_fail++;
                    $display("FAIL drop_%0d: pulse=%b cnt=%0d valid=%h, required 1/%0d/00", i, p_drop_pulse,
                             p_drop_cnt, p_out_valid, (i > 3) ? 3 : i);
                end
            end
            p_in_valid = (i < 5); p_in_bcast = 0;
            p_in_sel = 3'(5 + (i % 3)); p_in_data = 8'h77;
            #1;
            if (i < 5) begin
                n_checks++;
                if (p_in_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready_%0d: %b, required 1", i, p_in_ready); end
            end
        end
        p_in_valid = 1; p_in_sel = 4; p_in_data = 8'h44;
        @(negedge clk);
        p_in_valid = 0;
        n_checks++;
        if (p_drop_pulse !== 1'b0 || p_out_valid !== 5'h10 || p_out_data[32 +: 8] !== 8'h44 || p_drop_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL inrange_5ch: pulse=%b valid=%h d4=%h cnt=%0d, required 0/10/44/3", p_drop_pulse,
                     p_out_valid, p_out_data[32 +: 8], p_drop_cnt);
        end
    endtask

    // Reference: each channel is a queue of capacity one; the consumer pops when ready.
    task automatic test_random();
        logic [7:0] q [0:7][$];
        logic       exp_ready;
        out_ready = 8'hFF; in_valid = 0; in_bcast = 0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 500; c++) begin
            @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                n_checks++;
                if (out_valid[k] !== (q[k].size() != 0) ||
                    (q[k].size() != 0 && ch8(out_data, k) !== q[k][0])) begin
                    n_fail++;
                    $display("FAIL rand_out c=%0d ch%0d: v=%b d=%h, required v=%0d d=%h", c, k, out_valid[k],
                             ch8(out_data, k), q[k].size(), (q[k].size() != 0) ? q[k][0] : 8'h00);
                end
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            in_bcast  = ($urandom_range(0, 5) == 0);
            in_sel    = 3'($urandom_range(0, 7));
            in_data   = 8'($urandom);
            out_ready = 8'($urandom) | 8'($urandom);
            #1;
            exp_ready = 1'b1;
            for (int k = 0; k < 8; k++) begin
                if ((in_bcast || in_sel == 3'(k)) && q[k].size() != 0 && !out_ready[k]) exp_ready = 1'b0;
            end
            n_checks++;
            if (in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rand_ready c=%0d: in_ready=%b, required %b", c, in_ready, exp_ready);
            end
            for (int k = 0; k < 8; k++) begin
                if (q[k].size() != 0 && out_ready[k]) void'(q[k].pop_front());
                if (in_valid && exp_ready && (in_bcast || in_sel == 3'(k))) q[k].push_back(in_data);
            end
        end
        @(negedge clk);
        in_valid = 0;
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rand_no_drop: drop_cnt=%0d, required 0", drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_unicast_sweep();
        test_backpressure();
        test_broadcast();
        test_out_of_range_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
